icache_responder: RTL and testbench

- Direct-mapped instruction cache that answers the fetch stage's PC lookups with instruction, hit and ready indications.
- Services misses by refilling a whole line from the instruction memory port over a req/ack beat handshake.
- Sits between fetch and the memory arbiter; it is the responder end of fetch's instruction request.

---
 rtl/icache_responder.sv | 248 ++++++++++++++++++++++++
 tb/tb_icache_responder.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_responder.sv
`default_nettype none
// ============================================================================
//  Module   : icache_responder
//  Purpose  : Direct-mapped instruction cache answering the fetch stage's PC
//             lookups with zero-latency hit/instruction/ready indications,
//             and refilling whole lines from the instruction memory port over
//             a per-beat req/ack handshake on a miss.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK          in   1   clock
//    RESET        in   1   synchronous active-high reset
//    FE_PC        in   64  fetch PC to look up
//    FE_REQ       in   1   fetch requests an instruction this cycle
//    FLUSH        in   1   invalidate all lines (fence.i)
//    ICACHE_R     out  1   INSTRUCTION/CACHE_HIT/IAF valid for FE_PC
//    CACHE_HIT    out  1   lookup hit
//    INSTRUCTION  out  32  instruction word for FE_PC
//    IAF          out  1   instruction access fault (refill error)
//    MEM_REQ      out  1   refill beat request
//    MEM_ADDR     out  64  word address of the requested beat
//    MEM_ACK      in   1   beat accepted, MEM_RDATA valid
//    MEM_RDATA    in   32  beat data
//    MEM_ERR      in   1   with MEM_ACK: beat faulted
// ============================================================================
module icache_responder #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [63:0] FE_PC,
  input  logic        FE_REQ,
  input  logic        FLUSH,
  output logic        ICACHE_R,
  output logic        CACHE_HIT,
  output logic [31:0] INSTRUCTION,
  output logic        IAF,
  output logic        MEM_REQ,
  output logic [63:0] MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ERR
);

  localparam int C_OFF_BITS  = $clog2(LINE_WORDS * 4);
  localparam int C_IDX_BITS  = $clog2(LINES);
  localparam int C_TAG_BITS  = 64 - C_OFF_BITS - C_IDX_BITS;
  localparam int C_BEAT_BITS = $clog2(LINE_WORDS);
  localparam logic [C_BEAT_BITS-1:0] C_LAST_BEAT = C_BEAT_BITS'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Storage. Tag and data arrays carry no reset; only the valid bits do.
  logic [LINES-1:0]      r_valid;
  logic [C_TAG_BITS-1:0] r_tag  [LINES];
  logic [31:0]           r_data [LINES*LINE_WORDS];

  // Refill bookkeeping for the line being filled.
  logic [63:0]            r_base;
  logic [C_BEAT_BITS-1:0] r_beat;
  logic                   r_flush_seen;
  logic                   r_mem_req;
  logic [63:0]            r_mem_addr;

  // Lookup-side decode of FE_PC.
  logic [C_IDX_BITS-1:0]  w_idx;
  logic [C_TAG_BITS-1:0]  w_tag;
  logic [C_BEAT_BITS-1:0] w_word;
  logic                   w_hit;
  logic                   w_aligned;
  logic [31:0]            w_rd_word;

  // Fill-side decode of the latched line base.
  logic [C_IDX_BITS-1:0]  w_fill_idx;
  logic [C_TAG_BITS-1:0]  w_fill_tag;
  logic [C_BEAT_BITS-1:0] w_beat_nxt;

  logic w_start;
  logic w_beat_ok;
  logic w_beat_err;
  logic w_last;

  assign w_idx     = FE_PC[C_OFF_BITS +: C_IDX_BITS];
  assign w_tag     = FE_PC[63 -: C_TAG_BITS];
  assign w_word    = FE_PC[2 +: C_BEAT_BITS];
  assign w_aligned = (FE_PC[1:0] == 2'b00);
  assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_rd_word = r_data[{w_idx, w_word}];

  assign w_fill_idx = r_base[C_OFF_BITS +: C_IDX_BITS];
  assign w_fill_tag = r_base[63 -: C_TAG_BITS];
  assign w_beat_nxt = r_beat + C_BEAT_BITS'(1);

  // A fill may only start from IDLE on an aligned miss; a same-cycle FLUSH
  // suppresses it so the fence takes effect before any new line is fetched.
  assign w_start    = (r_state == S_IDLE) && FE_REQ && !w_hit && w_aligned && !FLUSH;
  assign w_beat_ok  = (r_state == S_FILL) && MEM_ACK && !MEM_ERR;
  assign w_beat_err = (r_state == S_FILL) && MEM_ACK && MEM_ERR;
  assign w_last     = w_beat_ok && (r_beat == C_LAST_BEAT);

  assign MEM_REQ  = r_mem_req;
  assign MEM_ADDR = r_mem_addr;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and fetch-side outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    ICACHE_R    = 1'b0;
    CACHE_HIT   = 1'b0;
    INSTRUCTION = 32'd0;
    IAF         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_FILL;
        end
        if (FE_REQ && !w_aligned) begin
          // Misaligned fetch: answer immediately with no data so that fetch
          // can raise its own misaligned exception; nothing is refilled.
          ICACHE_R = 1'b1;
        end else begin
          CACHE_HIT = w_hit;
          ICACHE_R  = FE_REQ && w_hit;
          if (w_hit) begin
            INSTRUCTION = w_rd_word;
          end
        end
      end
      S_FILL: begin
        if (w_beat_err) begin
          w_state_nxt = S_ERR;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        // One-cycle fault response; the line stays invalid so a later
        // request retries the refill instead of replaying the fault.
        w_state_nxt = S_IDLE;
        ICACHE_R    = 1'b1;
        IAF         = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (RESET) begin
      ICACHE_R    = 1'b0;
      CACHE_HIT   = 1'b0;
      INSTRUCTION = 32'd0;
      IAF         = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Refill control, beat counter and valid bits
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_valid      <= '0;
      r_base       <= 64'd0;
      r_beat       <= '0;
      r_flush_seen <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= 64'd0;
    end else begin
      if (w_start) begin
        r_base       <= {FE_PC[63:C_OFF_BITS], {C_OFF_BITS{1'b0}}};
        r_beat       <= '0;
        r_flush_seen <= 1'b0;
        r_mem_req    <= 1'b1;
        r_mem_addr   <= {FE_PC[63:C_OFF_BITS], {C_OFF_BITS{1'b0}}};
      end

      if (w_beat_ok) begin
        r_beat <= w_beat_nxt;
        if (w_last) begin
          r_mem_req <= 1'b0;
        end else begin
          r_mem_addr <= r_base + 64'({w_beat_nxt, 2'b00});
        end
      end

      if (w_beat_err) begin
        r_mem_req <= 1'b0;
      end

      // Remember a fence seen mid-fill so the completed line is not validated.
      if (FLUSH && (r_state == S_FILL)) begin
        r_flush_seen <= 1'b1;
      end

      if (FLUSH) begin
        r_valid <= '0;
      end else begin
        // The indexed line is evicted as soon as its refill starts: its data
        // words are about to be overwritten beat by beat.
        if (w_start) begin
          r_valid[w_idx] <= 1'b0;
        end
        if (w_last && !r_flush_seen) begin
          r_valid[w_fill_idx] <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Tag and data arrays (no reset). Writes are suppressed while RESET is high
  // so an ack arriving alongside reset is ignored.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RESET && w_beat_ok) begin
      r_data[{w_fill_idx, r_beat}] <= MEM_RDATA;
    end
    if (!RESET && w_last) begin
      r_tag[w_fill_idx] <= w_fill_tag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_responder
//  Purpose  : Self-checking bench for icache_responder: a directed vector
//             table covering the main refill/lookup scenarios, followed by
//             randomized traffic compared against a line-level cache model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_icache_responder;

  localparam int LINES = 16;
  localparam int LW    = 4;

  logic        CLK;
  logic        RESET;
  logic [63:0] FE_PC;
  logic        FE_REQ;
  logic        FLUSH;
  logic        ICACHE_R;
  logic        CACHE_HIT;
  logic [31:0] INSTRUCTION;
  logic        IAF;
  logic        MEM_REQ;
  logic [63:0] MEM_ADDR;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;
  logic        MEM_ERR;

  icache_responder #(.LINES(LINES), .LINE_WORDS(LW)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .FE_PC       (FE_PC),
    .FE_REQ      (FE_REQ),
    .FLUSH       (FLUSH),
    .ICACHE_R    (ICACHE_R),
    .CACHE_HIT   (CACHE_HIT),
    .INSTRUCTION (INSTRUCTION),
    .IAF         (IAF),
    .MEM_REQ     (MEM_REQ),
    .MEM_ADDR    (MEM_ADDR),
    .MEM_ACK     (MEM_ACK),
    .MEM_RDATA   (MEM_RDATA),
    .MEM_ERR     (MEM_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  // ---------------------------------------------------------------- memory
  // Backing store contents are a fixed function of the word address.
  function automatic logic [31:0] mem(input logic [63:0] a);
    logic [63:0] t;
    t = (a >> 2) * 64'h80 + 64'h13;
    return t[31:0] ^ a[63:32];
  endfunction

  // ------------------------------------------------------- reference model
  // The cache is modelled as "which line base address each index holds";
  // a hit returns mem(pc) directly. The refill is a transaction with a phase.
  int          ph;         // 0 lookup, 1 refilling, 2 refill done, 3 refill faulted
  logic [63:0] m_base;
  int          m_beat;
  bit          m_fl;
  bit          cv [LINES];
  logic [63:0] cb [LINES];

  function automatic logic [63:0] line_of(input logic [63:0] pc);
    return pc & ~64'(LW * 4 - 1);
  endfunction

  function automatic int idx_of(input logic [63:0] pc);
    return int'((pc / 64'(LW * 4)) % 64'(LINES));
  endfunction

  function automatic bit mhit(input logic [63:0] pc);
    return cv[idx_of(pc)] && (cb[idx_of(pc)] == line_of(pc));
  endfunction

  task automatic model_update(input logic rst, req, input logic [63:0] pc,
                              input logic fl, ack, err);
    bit h;
    h = mhit(pc);
    if (rst) begin
      ph = 0;
      for (int i = 0; i < LINES; i++) cv[i] = 0;
    end else begin
      case (ph)
        0: if (req && pc[1:0] == 2'b00 && !h && !fl) begin
             cv[idx_of(pc)] = 0;
             m_base = line_of(pc);
             m_beat = 0;
             m_fl   = 0;
             ph     = 1;
           end
        1: begin
             if (fl) m_fl = 1;
             if (ack) begin
               if (err) ph = 3;
               else begin
                 m_beat++;
                 if (m_beat == LW) begin
                   ph = 2;
                   if (!m_fl) begin
                     cv[idx_of(m_base)] = 1;
                     cb[idx_of(m_base)] = m_base;
                   end
                 end
               end
             end
           end
        default: ph = 0;
      endcase
      if (fl) for (int i = 0; i < LINES; i++) cv[i] = 0;
    end
  endtask

  // ------------------------------------------------------------ vector table
  typedef struct {
    logic        rst, req;
    logic [63:0] pc;
    logic        fl, ack, err;
    logic        r, hit;
    logic [31:0] instr;
    logic        iaf, mreq, chk;
    logic [63:0] addr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, req, input logic [63:0] pc,
                              input logic fl, ack, err, r, hit,
                              input logic [31:0] instr, input logic iaf, mreq, chk,
                              input logic [63:0] addr);
    vec_t v;
    v.rst = rst; v.req = req; v.pc = pc; v.fl = fl; v.ack = ack; v.err = err;
    v.r = r; v.hit = hit; v.instr = instr; v.iaf = iaf; v.mreq = mreq;
    v.chk = chk; v.addr = addr;
    return v;
  endfunction

  // Lookup cycle in IDLE (no refill expected to be outstanding).
  function automatic vec_t lk(input logic [63:0] pc, input logic req, fl, r, hit,
                              input logic [31:0] instr);
    return mk(0, req, pc, fl, 0, 0, r, hit, instr, 0, 0, 0, 64'd0);
  endfunction

  // Refill beat: fetch keeps requesting a different PC (redirect) meanwhile.
  function automatic vec_t fb(input logic [63:0] addr, input logic ack, err, fl);
    return mk(0, 1, 64'h40, fl, ack, err, 0, 0, 32'd0, 0, 1, 1, addr);
  endfunction

  function automatic vec_t dn();
    return mk(0, 1, 64'h40, 0, 0, 0, 0, 0, 32'd0, 0, 0, 0, 64'd0);
  endfunction

  function automatic vec_t er();
    return mk(0, 1, 64'h100, 0, 0, 0, 1, 0, 32'd0, 1, 0, 0, 64'd0);
  endfunction

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, req, input logic [63:0] pc,
                       input logic fl, ack, err);
    RESET   = rst;
    FE_REQ  = req;
    FE_PC   = pc;
    FLUSH   = fl;
    MEM_ACK = ack;
    MEM_ERR = err;
    MEM_RDATA = (ph == 1 && ack) ? mem(m_base + 64'(m_beat * 4)) : $urandom();
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic        r_rst, r_req, r_fl, r_ack, r_err;
    logic [63:0] r_pc;
    logic        e_r, e_hit, e_iaf;
    logic [31:0] e_instr;
    bit          h;

    ph = 0; m_base = 0; m_beat = 0; m_fl = 0;
    for (int i = 0; i < LINES; i++) begin cv[i] = 0; cb[i] = 0; end

    drive(1, 0, 64'd0, 0, 0, 0);
    next_cycle();
    next_cycle();

    // Reset state
    tbl.push_back(mk(1, 0, 64'd0, 0, 0, 0, 0, 0, 32'd0, 0, 0, 1, 64'd0));
    // Cold miss at 0x0, ack every cycle
    tbl.push_back(lk(64'h0, 1, 0, 0, 0, 32'd0));
    tbl.push_back(fb(64'h0, 1, 0, 0));
    tbl.push_back(fb(64'h4, 1, 0, 0));
    tbl.push_back(fb(64'h8, 1, 0, 0));
    tbl.push_back(fb(64'hC, 1, 0, 0));
    tbl.push_back(dn());
    tbl.push_back(lk(64'h0, 1, 0, 1, 1, 32'h13));
    tbl.push_back(lk(64'h8, 1, 0, 1, 1, 32'h113));
    tbl.push_back(lk(64'h4, 0, 0, 0, 1, 32'h93));
    // Conflict: 0x100 maps to index 0
    tbl.push_back(lk(64'h100, 1, 0, 0, 0, 32'd0));
    tbl.push_back(fb(64'h100, 1, 0, 0));
    tbl.push_back(fb(64'h104, 1, 0, 0));
    tbl.push_back(fb(64'h108, 1, 0, 0));
    tbl.push_back(fb(64'h10C, 1, 0, 0));
    tbl.push_back(dn());
    tbl.push_back(lk(64'h104, 1, 0, 1, 1, 32'h2093));
    // 0x0 evicted: misses, refill with a 3-cycle stall on beat 1
    tbl.push_back(lk(64'h0, 1, 0, 0, 0, 32'd0));
    tbl.push_back(fb(64'h0, 1, 0, 0));
    tbl.push_back(fb(64'h4, 0, 0, 0));
    tbl.push_back(fb(64'h4, 0, 0, 0));
    tbl.push_back(fb(64'h4, 0, 0, 0));
    tbl.push_back(fb(64'h4, 1, 0, 0));
    tbl.push_back(fb(64'h8, 1, 0, 0));
    tbl.push_back(fb(64'hC, 1, 0, 0));
    tbl.push_back(dn());
    tbl.push_back(lk(64'hC, 1, 0, 1, 1, 32'h193));
    // Fault on beat 2
    tbl.push_back(lk(64'h100, 1, 0, 0, 0, 32'd0));
    tbl.push_back(fb(64'h100, 1, 0, 0));
    tbl.push_back(fb(64'h104, 1, 0, 0));
    tbl.push_back(fb(64'h108, 1, 1, 0));
    tbl.push_back(er());
    tbl.push_back(lk(64'h100, 0, 0, 0, 0, 32'd0));
    tbl.push_back(lk(64'h0, 0, 0, 0, 0, 32'd0));
    // Retry restarts at beat 0
    tbl.push_back(lk(64'h100, 1, 0, 0, 0, 32'd0));
    tbl.push_back(fb(64'h100, 1, 0, 0));
    tbl.push_back(fb(64'h104, 1, 0, 0));
    tbl.push_back(fb(64'h108, 1, 0, 0));
    tbl.push_back(fb(64'h10C, 1, 0, 0));
    tbl.push_back(dn());
    tbl.push_back(lk(64'h108, 1, 0, 1, 1, 32'h2113));
    // Flush after fill
    tbl.push_back(lk(64'h108, 0, 1, 0, 1, 32'h2113));
    tbl.push_back(lk(64'h108, 0, 0, 0, 0, 32'd0));
    // Flush mid-fill: fill completes, line stays invalid
    tbl.push_back(lk(64'h108, 1, 0, 0, 0, 32'd0));
    tbl.push_back(fb(64'h100, 1, 0, 1));
    tbl.push_back(fb(64'h104, 1, 0, 0));
    tbl.push_back(fb(64'h108, 1, 0, 0));
    tbl.push_back(fb(64'h10C, 1, 0, 0));
    tbl.push_back(dn());
    tbl.push_back(lk(64'h108, 0, 0, 0, 0, 32'd0));
    // Fill index 1, then reset in the middle of a fill of index 0
    tbl.push_back(lk(64'h10, 1, 0, 0, 0, 32'd0));
    tbl.push_back(fb(64'h10, 1, 0, 0));
    tbl.push_back(fb(64'h14, 1, 0, 0));
    tbl.push_back(fb(64'h18, 1, 0, 0));
    tbl.push_back(fb(64'h1C, 1, 0, 0));
    tbl.push_back(dn());
    tbl.push_back(lk(64'h14, 1, 0, 1, 1, 32'h293));
    tbl.push_back(lk(64'h200, 1, 0, 0, 0, 32'd0));
    tbl.push_back(fb(64'h200, 1, 0, 0));
    tbl.push_back(mk(1, 0, 64'h200, 0, 1, 0, 0, 0, 32'd0, 0, 1, 1, 64'h204));
    tbl.push_back(mk(0, 0, 64'h14, 0, 0, 0, 0, 0, 32'd0, 0, 0, 1, 64'd0));
    tbl.push_back(lk(64'h200, 0, 0, 0, 0, 32'd0));
    // Misaligned PC: immediate answer, no refill
    tbl.push_back(lk(64'h2, 1, 0, 1, 0, 32'd0));
    tbl.push_back(lk(64'h2, 0, 0, 0, 0, 32'd0));
    // FLUSH in IDLE blocks a refill start
    tbl.push_back(lk(64'h0, 1, 1, 0, 0, 32'd0));
    tbl.push_back(lk(64'h0, 0, 0, 0, 0, 32'd0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].pc, tbl[i].fl, tbl[i].ack, tbl[i].err);
      #3;
      chk($sformatf("v%0d r/hit/iaf/req", i),
          {60'd0, ICACHE_R, CACHE_HIT, IAF, MEM_REQ},
          {60'd0, tbl[i].r, tbl[i].hit, tbl[i].iaf, tbl[i].mreq});
      chk($sformatf("v%0d instr", i), {32'd0, INSTRUCTION}, {32'd0, tbl[i].instr});
      if (tbl[i].chk) chk($sformatf("v%0d mem_addr", i), MEM_ADDR, tbl[i].addr);
      model_update(tbl[i].rst, tbl[i].req, tbl[i].pc, tbl[i].fl, tbl[i].ack, tbl[i].err);
      next_cycle();
    end

    // Randomized traffic against the line-level model
    for (int n = 0; n < 4000; n++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      r_req = ($urandom_range(0, 3) != 0);
      r_fl  = ($urandom_range(0, 39) == 0);
      r_ack = (ph == 1) && ($urandom_range(0, 9) < 6);
      r_err = r_ack && ($urandom_range(0, 15) == 0);
      r_pc  = 64'($urandom_range(0, 2)) * 64'h100
            + 64'($urandom_range(0, 3)) * 64'h10
            + 64'($urandom_range(0, 3)) * 64'h4;
      if ($urandom_range(0, 3) == 0) r_pc = r_pc | 64'hFFFF_0000_0000_0000;
      if ($urandom_range(0, 15) == 0) r_pc = r_pc | 64'($urandom_range(1, 3));

      drive(r_rst, r_req, r_pc, r_fl, r_ack, r_err);
      #3;

      h = mhit(r_pc);
      e_r = 0; e_hit = 0; e_iaf = 0; e_instr = 32'd0;
      if (!r_rst) begin
        if (ph == 0) begin
          if (r_req && r_pc[1:0] != 2'b00) e_r = 1;
          else begin
            e_hit   = h;
            e_r     = r_req && h;
            e_instr = h ? mem(line_of(r_pc) + 64'(r_pc[3:2]) * 4) : 32'd0;
          end
        end else if (ph == 3) begin
          e_r = 1; e_iaf = 1;
        end
      end

      chk($sformatf("rnd%0d r/hit/iaf/req", n),
          {60'd0, ICACHE_R, CACHE_HIT, IAF, MEM_REQ},
          {60'd0, e_r, e_hit, e_iaf, (ph == 1)});
      chk($sformatf("rnd%0d instr", n), {32'd0, INSTRUCTION}, {32'd0, e_instr});
      if (ph == 1) chk($sformatf("rnd%0d mem_addr", n), MEM_ADDR, m_base + 64'(m_beat * 4));

      model_update(r_rst, r_req, r_pc, r_fl, r_ack, r_err);
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
